// File: rtl/rd_stage_pkg.sv
// Shared constants for the read-side FWFT output stage.
package rd_stage_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage : rd_stage_pkg

// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage of the async FIFO: 2-entry skid buffer turning
// rempty/rinc/rdata into a registered valid/ready stream. RD_STAGE_CNT_EN adds xfer_cnt.
module rd_fwft_stage
    import rd_stage_pkg::*;
#(
    parameter int unsigned DSIZE   = 8
`ifdef RD_STAGE_CNT_EN
    ,
    parameter int unsigned CNTSIZE = 16
`endif
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             rflush,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       occ
`ifdef RD_STAGE_CNT_EN
    ,
    output logic [CNTSIZE-1:0] xfer_cnt
`endif
);

    logic [1:0]       r_occ;
    logic             r_valid;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;

    logic [1:0]       w_occ_nxt;
    logic [DSIZE-1:0] w_head_nxt;
    logic [DSIZE-1:0] w_tail_nxt;
    logic             w_pop;

    // State register
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_occ   <= OCC_EMPTY;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != OCC_EMPTY);
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Next-state: push always lands in head when head is free or leaving this cycle
    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        unique case (r_occ)
            OCC_EMPTY: begin
                if (rinc) begin
                    w_head_nxt = rdata;
                    w_occ_nxt  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (rinc && w_pop) begin
                    w_head_nxt = rdata;
                end else if (rinc) begin
                    w_tail_nxt = rdata;
                    w_occ_nxt  = OCC_FULL;
                end else if (w_pop) begin
                    w_occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_pop) begin
                    w_head_nxt = r_tail;
                    w_occ_nxt  = OCC_ONE;
                end
            end
            default: begin
                // Illegal occupancy recovers as if empty
                if (rinc) begin
                    w_head_nxt = rdata;
                    w_occ_nxt  = OCC_ONE;
                end else begin
                    w_occ_nxt  = OCC_EMPTY;
                end
            end
        endcase
        if (rflush) begin
            w_occ_nxt = OCC_EMPTY;
        end
    end

    // Outputs: rinc never looks at m_ready, so no ready-to-pop combinational path
    always_comb begin
        rinc    = ~rrst & ~rempty & ~rflush & (r_occ != OCC_FULL);
        w_pop   = r_valid & m_ready & ~rflush;
        m_valid = r_valid;
        m_data  = r_head;
        occ     = r_occ;
    end

`ifdef RD_STAGE_CNT_EN
    logic [CNTSIZE-1:0] r_xfer_cnt;

    // Delivered-word counter; survives rflush, cleared only by reset
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + CNTSIZE'(1);
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule : rd_fwft_stage

// File: tb/tb_rd_fwft_stage.sv
// Bench for rd_fwft_stage: directed scenarios plus random traffic against a queue model.
module tb_rd_fwft_stage;

    localparam int unsigned DSIZE   = 8;
    localparam int unsigned CNTSIZE = 8;

    logic             rclk = 1'b0;
    logic             rrst;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             rflush;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;
    logic [1:0]       occ;
`ifdef RD_STAGE_CNT_EN
    logic [CNTSIZE-1:0] xfer_cnt;
`endif

    always #5 rclk = ~rclk;

    rd_fwft_stage #(
        .DSIZE   (DSIZE)
`ifdef RD_STAGE_CNT_EN
        ,
        .CNTSIZE (CNTSIZE)
`endif
    ) u_dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .rflush  (rflush),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .occ     (occ)
`ifdef RD_STAGE_CNT_EN
        ,
        .xfer_cnt(xfer_cnt)
`endif
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model: ordered list of buffered words, capacity two
    logic [DSIZE-1:0] mdl_q[$];
    logic             mdl_head_zero;
    int unsigned      mdl_cnt;
    logic [DSIZE-1:0] src;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic emp, input logic fl, input logic rdy);
        logic exp_rinc;
        @(negedge rclk);
        rrst    = rst;
        rempty  = emp;
        rflush  = fl;
        m_ready = rdy;
        rdata   = src;
        #1;
        exp_rinc = !rst && !emp && !fl && (mdl_q.size() < 2);
        check("rinc",    32'(rinc),    32'(exp_rinc));
        check("m_valid", 32'(m_valid), 32'(mdl_q.size() != 0));
        check("occ",     32'(occ),     32'(mdl_q.size()));
        if (mdl_q.size() != 0) begin
            check("m_data", 32'(m_data), 32'(mdl_q[0]));
        end else if (mdl_head_zero) begin
            check("m_data_rst", 32'(m_data), 32'd0);
        end
`ifdef RD_STAGE_CNT_EN
        check("xfer_cnt", 32'(xfer_cnt), 32'(mdl_cnt % (32'd1 << CNTSIZE)));
`endif
        if (rst) begin
            mdl_q.delete();
            mdl_head_zero = 1'b1;
            mdl_cnt = 0;
        end else if (fl) begin
            mdl_q.delete();
        end else begin
            if (mdl_q.size() != 0 && rdy) begin
                void'(mdl_q.pop_front());
                mdl_cnt++;
            end
            if (exp_rinc) begin
                mdl_q.push_back(src);
                mdl_head_zero = 1'b0;
                src = src + DSIZE'(1);
            end
        end
    endtask

    initial begin
        rrst = 1'b1; rempty = 1'b0; rflush = 1'b0; m_ready = 1'b1; rdata = '0;
        src = '0; mdl_cnt = 0; mdl_head_zero = 1'b1;
        repeat (2) @(posedge rclk);

        // Reset held with data available, then streaming 0x01..0x10
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        src = DSIZE'(8'h01);
        repeat (18) step(1'b0, (src > DSIZE'(8'h10)), 1'b0, 1'b1);

        // Backpressure once 0x03 has been pushed
        step(1'b1, 1'b0, 1'b0, 1'b1);
        src = DSIZE'(8'h01);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Empty boundary: drain, then refill
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Flush with two words buffered and m_ready high
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);
        src = DSIZE'(8'hA0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Long stream for counter wrap, then flush and reset
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (301) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r_rst, r_emp, r_fl, r_rdy;
            r_rst = ($urandom_range(0, 99) < 2);
            r_emp = ($urandom_range(0, 99) < 30);
            r_fl  = ($urandom_range(0, 99) < 5);
            r_rdy = ($urandom_range(0, 99) < 60);
            src   = DSIZE'($urandom);
            step(r_rst, r_emp, r_fl, r_rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rd_fwft_stage
